// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, range-checks the
// immediate and queues results (including rejected requests) in a 2-entry output FIFO.
module inst_encoder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_class,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  enc_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [6:0] OpR      = 7'h33;
  localparam logic [6:0] OpOpImm  = 7'h13;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;

  logic        fits12, fits13, fits21, shamt_ok, upper_ok, is_shift, funct7_ok;
  logic        enc_err;
  logic [31:0] enc_word, enc_instr;

  // An immediate fits N signed bits when every bit from N-1 upward equals the sign.
  assign fits12    = (&in_imm[DATA_WIDTH-1:11]) | ~(|in_imm[DATA_WIDTH-1:11]);
  assign fits13    = (&in_imm[DATA_WIDTH-1:12]) | ~(|in_imm[DATA_WIDTH-1:12]);
  assign fits21    = (&in_imm[DATA_WIDTH-1:20]) | ~(|in_imm[DATA_WIDTH-1:20]);
  assign shamt_ok  = ~(|in_imm[DATA_WIDTH-1:5]);
  assign upper_ok  = ((&in_imm[DATA_WIDTH-1:31]) | ~(|in_imm[DATA_WIDTH-1:31])) &&
                     (in_imm[11:0] == 12'd0);
  assign is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign funct7_ok = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);

  always_comb begin
    enc_err  = 1'b0;
    enc_word = '0;
    case (in_class)
      4'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OpR};
      4'd1: begin
        if (is_shift) begin
          enc_err  = !shamt_ok || !funct7_ok;
          enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OpOpImm};
        end else begin
          enc_err  = !fits12;
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpOpImm};
        end
      end
      4'd2: begin
        enc_err  = !fits12;
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpLoad};
      end
      4'd3: begin
        enc_err  = !fits12;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OpStore};
      end
      4'd4: begin
        enc_err  = !fits13 || in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], OpBranch};
      end
      4'd5: begin
        enc_err  = !fits12;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpJalr};
      end
      4'd6: begin
        enc_err  = !fits21 || in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpJal};
      end
      4'd7: begin
        enc_err  = !upper_ok;
        enc_word = {in_imm[31:12], in_rd, OpLui};
      end
      4'd8: begin
        enc_err  = !upper_ok;
        enc_word = {in_imm[31:12], in_rd, OpAuipc};
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign enc_instr = enc_err ? 32'd0 : enc_word;

  logic [1:0]           count_q;
  logic                 wr_ptr_q, rd_ptr_q, ready_q;
  logic [31:0]          instr_q [2];
  logic                 err_q   [2];
  logic [CNT_WIDTH-1:0] enc_cnt_q, err_cnt_q;
  logic                 push, pop;

  // ready_q keeps in_ready low during reset and for the first cycle after release.
  assign in_ready  = ready_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : 32'd0;
  assign out_err   = out_valid ? err_q[rd_ptr_q] : 1'b0;
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ready_q    <= 1'b0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      err_q[0]   <= 1'b0;
      err_q[1]   <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) begin
        instr_q[wr_ptr_q] <= enc_instr;
        err_q[wr_ptr_q]   <= enc_err;
        wr_ptr_q          <= ~wr_ptr_q;
        if (enc_err) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (enc_cnt_q != '1) enc_cnt_q <= enc_cnt_q + CNT_WIDTH'(1);
        end
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: per-cycle scoreboard against an arithmetic encoding model,
// plus directed vectors with hand-computed words.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid, out_err, out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] enc_count, err_count;

  logic        in_ready_4, out_valid_4, out_err_4;
  logic [31:0] out_instr_4;
  logic [3:0]  enc_count_4, err_count_4;

  int n_cmp = 0;
  int n_fail = 0;
  int pops = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  inst_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_instr(out_instr_4),
    .out_err(out_err_4), .enc_count(enc_count_4), .err_count(err_count_4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the ISA field layout; result is {err, word}.
  function automatic logic [32:0] model_enc(input int cls, rd, rs1, rs2, f3, f7, imm);
    logic [31:0] u, w, base_i;
    logic        err;
    int          op [9];
    op = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h67, 'h6F, 'h37, 'h17};
    u = imm;
    err = 1'b0;
    w = 0;
    if (cls > 8) return {1'b1, 32'd0};
    base_i = (rs1 << 15) | (f3 << 12) | (rd << 7) | op[cls];
    case (cls)
      0: w = (f7 << 25) | (rs2 << 20) | base_i;
      1, 2, 5: begin
        if (cls == 1 && (f3 == 1 || f3 == 5)) begin
          err = imm < 0 || imm > 31 || (f7 != 0 && f7 != 32);
          w = (f7 << 25) | ((u & 31) << 20) | base_i;
        end else begin
          err = imm < -2048 || imm > 2047;
          if (cls == 5) base_i = (rs1 << 15) | (rd << 7) | op[cls];
          w = ((u & 'hFFF) << 20) | base_i;
        end
      end
      3: begin
        err = imm < -2048 || imm > 2047;
        w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
            ((u & 'h1F) << 7) | op[cls];
      end
      4: begin
        err = imm < -4096 || imm > 4094 || (imm % 2 != 0);
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | op[cls];
      end
      6: begin
        err = imm < -(1 << 20) || imm > (1 << 20) - 2 || (imm % 2 != 0);
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 'hFF) << 12) | (rd << 7) | op[cls];
      end
      default: begin
        err = (u & 'hFFF) != 0;
        w = (u & 32'hFFFFF000) | (rd << 7) | op[cls];
      end
    endcase
    return {err, err ? 32'd0 : w};
  endfunction

  // Scoreboard state reflects the DUT after the most recent rising edge.
  logic [32:0] q [$];
  bit          rdy_m = 0;
  int          exp_enc = 0, exp_err = 0, exp_enc4 = 0, exp_err4 = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      rdy_m = 0;
      exp_enc = 0; exp_err = 0; exp_enc4 = 0; exp_err4 = 0;
    end else begin
      bit push, pop;
      logic [32:0] e;
      check("in_ready", 32'(in_ready), 32'(rdy_m && q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_instr", out_instr, q[0][31:0]);
        check("out_err", 32'(out_err), 32'(q[0][32]));
      end
      check("enc_count", 32'(enc_count), exp_enc);
      check("err_count", 32'(err_count), exp_err);
      check("enc_count_w4", 32'(enc_count_4), exp_enc4);
      check("err_count_w4", 32'(err_count_4), exp_err4);
      push = in_valid && rdy_m && q.size() < 2;
      pop  = q.size() > 0 && out_ready;
      if (pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (push) begin
        e = model_enc(int'(in_class), int'(in_rd), int'(in_rs1), int'(in_rs2),
                      int'(in_funct3), int'(in_funct7), int'($signed(in_imm)));
        q.push_back(e);
        if (e[32]) begin
          if (exp_err < 65535) exp_err++;
          if (exp_err4 < 15) exp_err4++;
        end else begin
          if (exp_enc < 65535) exp_enc++;
          if (exp_enc4 < 15) exp_enc4++;
        end
      end
      rdy_m = 1;
    end
  end

  task automatic drive(input int cls, rd, rs1, rs2, f3, f7, imm);
    in_class  = 4'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 32'(imm);
    in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc = 0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: request not accepted within 40 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input int cls, rd, rs1, rs2, f3, f7, imm);
    drive(cls, rd, rs1, rs2, f3, f7, imm);
    wait_accept();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_random_legal();
    int cls, f3, f7, imm;
    cls = $urandom_range(0, 8);
    f3  = $urandom_range(0, 7);
    f7  = $urandom_range(0, 127);
    case (cls)
      1: begin
        if (f3 == 1 || f3 == 5) begin
          f7  = $urandom_range(0, 1) * 32;
          imm = $urandom_range(0, 31);
        end else imm = $urandom_range(0, 4095) - 2048;
      end
      2, 3, 5: imm = $urandom_range(0, 4095) - 2048;
      4:       imm = ($urandom_range(0, 4095) - 2048) * 2;
      6:       imm = ($urandom_range(0, (1 << 20) - 1) - (1 << 19)) * 2;
      7, 8:    imm = int'($urandom) & 32'hFFFFF000;
      default: imm = $urandom;
    endcase
    send(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f3, f7, imm);
  endtask

  initial begin
    int snap;
    // Model pinned to hand-computed words.
    check("model_addi", model_enc(1, 1, 0, 0, 0, 0, 5), {1'b0, 32'h00500093});
    check("model_sw", model_enc(3, 0, 1, 2, 2, 0, 8), {1'b0, 32'h0020A423});
    check("model_beq", model_enc(4, 0, 0, 0, 0, 0, -4), {1'b0, 32'hFE000EE3});
    check("model_srai", model_enc(1, 1, 2, 0, 5, 'h20, 3), {1'b0, 32'h40315093});
    check("model_lui", model_enc(7, 5, 0, 0, 0, 0, 'h12345000), {1'b0, 32'h123452B7});

    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_counts", 32'({enc_count, err_count}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("in_ready_first_cycle", 32'(in_ready), 0);
    cycles(1);
    check("in_ready_after_release", 32'(in_ready), 1);

    out_ready = 1'b1;
    send(1, 1, 0, 0, 0, 0, 5);
    check("addi_word", out_instr, 32'h00500093);
    check("addi_enc_count", 32'(enc_count), 1);
    send(3, 0, 1, 2, 2, 0, 8);
    check("sw_word", out_instr, 32'h0020A423);
    send(4, 0, 0, 0, 0, 0, -4);
    check("beq_word", out_instr, 32'hFE000EE3);
    send(1, 1, 2, 0, 5, 'h20, 3);
    check("srai_word", out_instr, 32'h40315093);
    send(7, 5, 0, 0, 0, 0, 'h12345000);
    check("lui_word", out_instr, 32'h123452B7);

    send(1, 1, 0, 0, 0, 0, 2048);
    check("err_imm_flag", 32'(out_err), 1);
    check("err_imm_word", out_instr, 0);
    send(4, 0, 0, 0, 0, 0, 3);
    check("err_branch_flag", 32'(out_err), 1);
    send(12, 3, 3, 3, 3, 3, 0);
    check("err_class_flag", 32'(out_err), 1);
    cycles(2);
    check("err_count_3", 32'(err_count), 3);
    check("enc_count_held", 32'(enc_count), 5);

    // Backpressure: two fill the buffer, the third waits for the drain.
    out_ready = 1'b0;
    send(1, 1, 0, 0, 0, 0, 1);
    send(1, 2, 0, 0, 0, 0, 2);
    check("bp_in_ready_low", 32'(in_ready), 0);
    check("bp_head_first", out_instr, 32'h00100093);
    drive(1, 3, 0, 0, 0, 0, 3);
    cycles(3);
    check("bp_head_stable", out_instr, 32'h00100093);
    out_ready = 1'b1;
    wait_accept();
    check("bp_third_word", out_instr, 32'h00300193);
    cycles(2);

    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(1);
    snap = pops;
    for (int i = 0; i < 100; i++) send_random_legal();
    check("stream_enc_count", 32'(enc_count), 100);
    cycles(3);
    check("stream_pops", 32'(pops - snap), 100);

    // Reset between edges with two entries buffered.
    out_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    send(0, 4, 5, 6, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_instr", out_instr, 0);
    check("mid_rst_enc", 32'(enc_count), 0);
    check("mid_rst_err", 32'(err_count), 0);
    cycles(2);
    reset_n = 1'b1;
    check("mid_rst_ready_low", 32'(in_ready), 0);
    cycles(1);
    check("mid_rst_ready_back", 32'(in_ready), 1);

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(9 + (i % 7), 1, 1, 1, 0, 0, 0);
    cycles(3);
    check("sat_err_count_w4", 32'(err_count_4), 15);
    check("sat_err_count_w16", 32'(err_count), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Buffered RISC-V RV32I instruction encoder: the write-side counterpart of the ID-stage decoder. It accepts decoded instruction fields (class, rd, rs1, rs2, funct3, funct7, sign-extended immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. It range-checks the immediate and queues results in a 2-entry output buffer. It sits in front of instruction-memory writers such as the program loader and the self-test generator, and keeps running counts of encoded and rejected requests.

## Interface
- DATA_WIDTH, 32: width of `in_imm`; must be ≥ 32.
- CNT_WIDTH, 16: width of the statistics counters.

- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  encoder can accept a request.
- in_class  input  4  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 JAL, 7 LUI, 8 AUIPC; 9–15 illegal.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field; used by R and OP-IMM shifts.
- in_imm  input  DATA_WIDTH  sign-extended byte/absolute immediate; for LUI/AUIPC, the full upper value.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer accepts the head.
- out_instr  output  32  encoded word at the buffer head.
- out_err  output  1  the head request was rejected; `out_instr` is 0.
- enc_count  output  CNT_WIDTH  accepted requests with `err` = 0; saturating.
- err_count  output  CNT_WIDTH  accepted requests with `err` = 1; saturating.

## Operation
- Opcodes: R 0x33, OP-IMM 0x13, LOAD 0x03, STORE 0x23, BRANCH 0x63, JALR 0x67, JAL 0x6F, LUI 0x37, AUIPC 0x17.
- Packing, MSB to LSB:
  - R: funct7, rs2, rs1, funct3, rd, op.
  - OP-IMM / LOAD: imm[11:0], rs1, funct3, rd, op.
  - OP-IMM shifts (funct3 001 or 101): funct7, imm[4:0], rs1, funct3, rd, op.
  - JALR: same as LOAD, with funct3 forced to 000.
  - STORE: imm[11:5], rs2, rs1, funct3, imm[4:0], op.
  - BRANCH: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op.
  - JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - LUI / AUIPC: imm[31:12], rd, op.
- Fields unused by a class are ignored, whatever their value.
- Error conditions (`err` = 1); any one is sufficient:
  - illegal class (9–15);
  - I/S imm outside [-2048, 2047];
  - shift imm outside [0, 31];
  - shift funct7 not 0x00 or 0x20;
  - BRANCH imm outside [-4096, 4094] or imm[0] = 1;
  - JAL imm outside [-2^20, 2^20-2] or imm[0] = 1;
  - LUI/AUIPC imm[11:0] ≠ 0, or (DATA_WIDTH > 32) upper bits not a sign-extension of bit 31.
- An errored request still occupies a buffer entry, with `out_instr` = 0 and `out_err` = 1. It is never dropped.
- Buffer: 2-entry circular FIFO (wr_ptr, rd_ptr, count 0..2), in-order.
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
- Counters: incremented on push, selected by `err`; each holds at all-ones once saturated.

## Timing
- Reset (asynchronous, effective immediately):
  - count, pointers, enc_count, err_count = 0;
  - `out_valid` = 0, `out_instr` = 0, `out_err` = 0;
  - `in_ready` = 1 one cycle after `reset_n` deasserts; it is held at 0 while `reset_n` is low.
- `in_ready` = (count < 2), derived from registered state only. There is no combinational path from `out_ready`.
- `out_valid` = (count > 0). `out_instr` and `out_err` are driven from registers.
- Latency: a request pushed at edge N is visible on `out_*` after edge N (one cycle) when the buffer was empty.
- Throughput: one request per cycle when `out_ready` is held at 1.
- Simultaneous push and pop at count 1: count stays 1, and the new entry becomes head after the pop.
- Push at count 2 is impossible because `in_ready` = 0. A pop at count 2 raises `in_ready` on the following cycle.
- `out_instr`/`out_err` are stable while `out_valid && !out_ready`.
- Inputs are sampled only on push; changes while `in_ready` = 0 have no effect.
- Reset asserted mid-operation discards all buffered entries; no partial output appears.

## Test plan
- Single requests, each drained with `out_ready` = 1:
  - addi (class 1, rd 1, rs1 0, f3 0, imm 5) -> 0x00500093 one cycle later, enc_count = 1.
  - sw (class 3, rs1 1, rs2 2, f3 2, imm 8) -> 0x0020A423.
  - beq (class 4, rs1 0, rs2 0, f3 0, imm -4) -> 0xFE000EE3.
  - srai (class 1, f3 5, funct7 0x20, rd 1, rs1 2, imm 3) -> 0x40315093.
  - lui (class 7, rd 5, imm 0x12345000) -> 0x123452B7.
- Errors:
  - class 1 with imm 2048 -> out_err 1, out_instr 0.
  - class 4 with imm 3 -> out_err 1.
  - class 12 -> out_err 1.
  - After the three: err_count = 3 and enc_count unchanged.
- Backpressure: `out_ready` = 0, three back-to-back requests -> first two accepted, `in_ready` = 0 from the cycle after the second push. Raising `out_ready` drains them in order; the third is then accepted and appears one cycle after its push.
- Streaming: 100 random legal requests with `out_ready` = 1 -> 100 outputs in order, one per cycle after the first, matching a reference packing model. enc_count = 100.
- Reset mid-operation: buffer holding 2 entries, pull `reset_n` low between edges -> `out_valid`, `out_instr`, and both counters go to 0 without a clock edge. `in_ready` returns to 1 one cycle after release.
- Saturation with CNT_WIDTH = 4: 20 erroring requests -> err_count holds at 15.
